// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the parametrised UART receiver:
//                FSM state encodings, parity-mode constants and a parity
//                helper function.
//  Revision    : 1.0  Initial release
// ============================================================================
package uart_pkg;

    // FSM state encoding, also exported on the debug 'state' port.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // Parity modes selected by the receiver's PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Widest supported data word; narrower words are zero-extended before
    // being passed to parity_of (zero padding does not change the XOR).
    localparam int MAX_DATA_BITS = 9;

    // XOR reduction of a data word: 1 when the word holds an odd number of ones.
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Free-running oversample divider. Counts 0..BAUD_DIV-1 and
//                raises 'tick' for one clk while the count is at its top.
//  Ports       : clk   in   system clock
//                reset in   synchronous active-high reset (count -> 0)
//                tick  out  one-clk pulse every BAUD_DIV clocks
//  Revision    : 1.0  Initial release
// ============================================================================
module uart_baud_tick #(
    parameter int BAUD_DIV = 651
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int                  c_cnt_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(BAUD_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver. Two-flop input synchroniser,
//                oversampled mid-bit start validation, configurable data
//                width / parity / stop bits, and a one-entry valid/ready
//                holding register with parity, framing and overrun reporting.
//  Ports       : clk        in   system clock
//                reset      in   synchronous active-high reset
//                rx         in   asynchronous serial input, idle high
//                data_out   out  received word, LSB received first
//                data_valid out  holding register full
//                data_ready in   consumer accepts on data_valid && data_ready
//                parity_err out  parity mismatch for the held word
//                frame_err  out  a stop bit sampled low for the held word
//                overrun    out  one-clk pulse when a completed frame is dropped
//                busy       out  FSM is not idle
//                state      out  current FSM state (debug)
//  Revision    : 1.0  Initial release
// ============================================================================
module uart_rx_param #(
    parameter int BAUD_DIV   = 651,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [2:0]           state
);

    import uart_pkg::*;

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                   c_scnt_w     = $clog2(OVERSAMPLE);
    localparam int                   c_bcnt_w     = $clog2(DATA_BITS);
    // START validates at the middle of the start bit; DATA/PARITY/STOP sample
    // one full bit later each, i.e. in the middle of every following bit.
    localparam logic [c_scnt_w-1:0]  c_half_last  = c_scnt_w'(OVERSAMPLE/2 - 1);
    localparam logic [c_scnt_w-1:0]  c_bit_last   = c_scnt_w'(OVERSAMPLE - 1);
    localparam logic [c_bcnt_w-1:0]  c_last_bit   = c_bcnt_w'(DATA_BITS - 1);
    localparam logic                 c_last_stop  = 1'(STOP_BITS - 1);
    localparam logic                 c_par_expect = (PARITY == PAR_ODD);

    // ------------------------------------------------------------------------
    // Input synchroniser (clears to the idle-high line level)
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // ------------------------------------------------------------------------
    // Oversample tick
    // ------------------------------------------------------------------------
    logic w_tick;

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    logic [2:0]              r_state;
    logic [c_scnt_w-1:0]     r_s_cnt;
    logic [c_bcnt_w-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]    r_shift;
    logic                    r_perr;
    logic                    r_ferr;
    logic                    r_stop_cnt;
    logic                    r_deliver;
    logic                    w_sample;
    logic [MAX_DATA_BITS-1:0] w_word_ext;

    assign w_sample = (r_s_cnt == c_bit_last);

    generate
        if (DATA_BITS < MAX_DATA_BITS) begin : g_word_pad
            assign w_word_ext = {{(MAX_DATA_BITS-DATA_BITS){1'b0}}, r_shift};
        end else begin : g_word_full
            assign w_word_ext = r_shift;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_s_cnt    <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_deliver  <= 1'b0;
        end else begin
            r_deliver <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rx_s) begin
                            r_state <= S_START;
                            r_s_cnt <= '0;
                        end
                    end

                    S_START: begin
                        if (r_s_cnt == c_half_last) begin
                            if (!w_rx_s) begin
                                // Genuine start bit: clear per-frame status here,
                                // not on delivery, so the previous frame's flags
                                // remain valid until the output stage copies them.
                                r_state    <= S_DATA;
                                r_s_cnt    <= '0;
                                r_bit_cnt  <= '0;
                                r_perr     <= 1'b0;
                                r_ferr     <= 1'b0;
                                r_stop_cnt <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (w_sample) begin
                            // Right shift: after DATA_BITS samples the first
                            // received bit lands in bit 0.
                            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_s_cnt   <= '0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_state <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end

                    S_PARITY: begin
                        if (w_sample) begin
                            r_perr  <= ((parity_of(w_word_ext) ^ w_rx_s) != c_par_expect);
                            r_s_cnt <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end

                    S_STOP: begin
                        if (w_sample) begin
                            if (!w_rx_s) begin
                                r_ferr <= 1'b1;
                            end
                            r_s_cnt <= '0;
                            if (r_stop_cnt == c_last_stop) begin
                                // Return to idle on the sampling tick so a start
                                // edge in the second half of the stop bit is seen.
                                r_deliver <= 1'b1;
                                r_state   <= S_IDLE;
                            end else begin
                                r_stop_cnt <= 1'b1;
                            end
                        end else begin
                            r_s_cnt <= r_s_cnt + 1'b1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output holding register
    // ------------------------------------------------------------------------
    // r_shift/r_perr/r_ferr are stable on the clk after r_deliver: the next
    // tick (and so the next FSM update) is at least two clocks away.
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_accept;

    assign w_accept = r_data_valid & data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_deliver) begin
                if (!r_data_valid || w_accept) begin
                    r_data_out   <= r_shift;
                    r_parity_err <= r_perr;
                    r_frame_err  <= r_ferr;
                    r_data_valid <= 1'b1;
                end else begin
                    // Holding register still owned by the consumer: the new
                    // frame is dropped and the held word is left untouched.
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Scoreboard bench for uart_rx_param. Three receivers share
//                clk/reset: A = 8N1, B = 7 data bits even parity, C = 8N2,
//                all at BAUD_DIV=4, OVERSAMPLE=16 (64 clk per bit).
//  Revision    : 1.0  Initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int c_bit_clk = 64;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic       valid_a, valid_b, valid_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       ovr_a, ovr_b, ovr_c;
    logic       busy_a, busy_b, busy_c;
    logic [2:0] state_a, state_b, state_c;

    uart_rx_param #(.BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .data_out(data_a), .data_valid(valid_a),
        .data_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
        .busy(busy_a), .state(state_a));

    uart_rx_param #(.BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .data_out(data_b), .data_valid(valid_b),
        .data_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
        .busy(busy_b), .state(state_b));

    uart_rx_param #(.BAUD_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_c (
        .clk(clk), .reset(reset), .rx(rx_c), .data_out(data_c), .data_valid(valid_c),
        .data_ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c),
        .busy(busy_c), .state(state_c));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   ovr_cnt_a = 0, ovr_cnt_b = 0, ovr_cnt_c = 0;
    int   t_start = 0;
    bit   lat_en = 1'b0;
    logic [7:0] held_a = '0;
    bit   hold_seen_a = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        n_vec++;
        if (got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s: got=%0d expected in [%0d,%0d]", name, got, lo, hi);
        end
    endtask

    // ---------------------------------------------------------------- monitors
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (valid_a && ready_a) begin
                if (q_a.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL a_unexpected_word: got=0x%0h expected=none", data_a);
                end else begin
                    e = q_a.pop_front();
                    chk("a_data", {24'b0, data_a}, {23'b0, e.data});
                    chk("a_parity_err", {31'b0, perr_a}, {31'b0, e.perr});
                    chk("a_frame_err", {31'b0, ferr_a}, {31'b0, e.ferr});
                    if (lat_en) begin
                        chk_range("a_latency_clk", cyc - t_start, 600, 620);
                        lat_en = 1'b0;
                    end
                end
            end
            // Held word must not change while the consumer is stalled.
            if (valid_a && !ready_a) begin
                if (hold_seen_a) chk("a_hold_stable", {24'b0, data_a}, {24'b0, held_a});
                held_a      = data_a;
                hold_seen_a = 1'b1;
            end else begin
                hold_seen_a = 1'b0;
            end
            if (ovr_a) ovr_cnt_a++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (valid_b && ready_b) begin
                if (q_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL b_unexpected_word: got=0x%0h expected=none", data_b);
                end else begin
                    e = q_b.pop_front();
                    chk("b_data", {25'b0, data_b}, {23'b0, e.data});
                    chk("b_parity_err", {31'b0, perr_b}, {31'b0, e.perr});
                    chk("b_frame_err", {31'b0, ferr_b}, {31'b0, e.ferr});
                end
            end
            if (ovr_b) ovr_cnt_b++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (valid_c && ready_c) begin
                if (q_c.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL c_unexpected_word: got=0x%0h expected=none", data_c);
                end else begin
                    e = q_c.pop_front();
                    chk("c_data", {24'b0, data_c}, {23'b0, e.data});
                    chk("c_parity_err", {31'b0, perr_c}, {31'b0, e.perr});
                    chk("c_frame_err", {31'b0, ferr_c}, {31'b0, e.ferr});
                end
            end
            if (ovr_c) ovr_cnt_c++;
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic set_rx(input int sel, input logic b);
        case (sel)
            0:       rx_a = b;
            1:       rx_b = b;
            default: rx_c = b;
        endcase
    endtask

    task automatic hold_bit();
        repeat (c_bit_clk) @(negedge clk);
    endtask

    // Start bit, data LSB first, optional parity bit, stop bits, one idle bit.
    task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit,
                              input int nstop, input logic [1:0] stops);
        @(negedge clk);
        set_rx(sel, 1'b0);
        if (sel == 0) t_start = cyc;
        hold_bit();
        for (int i = 0; i < nbits; i++) begin
            set_rx(sel, data[i]);
            hold_bit();
        end
        if (has_par) begin
            set_rx(sel, par_bit);
            hold_bit();
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(sel, stops[i]);
            hold_bit();
        end
        set_rx(sel, 1'b1);
        hold_bit();
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values
        repeat (4) @(negedge clk);
        chk("rst_data_out",   {24'b0, data_a}, 32'h0);
        chk("rst_data_valid", {31'b0, valid_a}, 32'h0);
        chk("rst_parity_err", {31'b0, perr_a}, 32'h0);
        chk("rst_frame_err",  {31'b0, ferr_a}, 32'h0);
        chk("rst_overrun",    {31'b0, ovr_a}, 32'h0);
        chk("rst_busy",       {31'b0, busy_a}, 32'h0);
        chk("rst_state",      {29'b0, state_a}, 32'h0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // ---- 8N1 0xA5 with latency measurement
        lat_en = 1'b1;
        q_a.push_back('{data: 9'h0A5, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
        chk("a_latency_seen", {31'b0, lat_en}, 32'h0);

        // ---- 3-tick glitch: start rejected, no delivery
        @(negedge clk);
        rx_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_high", {31'b0, busy_a}, 32'h1);
        repeat (2) @(negedge clk);
        rx_a = 1'b1;
        repeat (c_bit_clk) @(negedge clk);
        chk("glitch_busy_low", {31'b0, busy_a}, 32'h0);
        chk("glitch_state_idle", {29'b0, state_a}, 32'h0);

        // ---- 7E1: 0x55 has four ones, correct even parity bit is 0
        q_b.push_back('{data: 9'h055, perr: 1'b1, ferr: 1'b0});
        send_frame(1, 9'h055, 7, 1'b1, 1'b1, 1, 2'b11);
        q_b.push_back('{data: 9'h055, perr: 1'b0, ferr: 1'b0});
        send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1, 2'b11);
        // 0x07 has three ones, correct even parity bit is 1
        q_b.push_back('{data: 9'h007, perr: 1'b0, ferr: 1'b0});
        send_frame(1, 9'h007, 7, 1'b1, 1'b1, 1, 2'b11);

        // ---- framing error, then a clean frame to show recovery
        q_a.push_back('{data: 9'h03C, perr: 1'b0, ferr: 1'b1});
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b10);
        repeat (c_bit_clk) @(negedge clk);
        q_a.push_back('{data: 9'h05A, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b11);

        // ---- 8N2: clean frame, then only the second stop low
        q_c.push_back('{data: 9'h096, perr: 1'b0, ferr: 1'b0});
        send_frame(2, 9'h096, 8, 1'b0, 1'b0, 2, 2'b11);
        q_c.push_back('{data: 9'h03C, perr: 1'b0, ferr: 1'b1});
        send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2, 2'b01);
        repeat (c_bit_clk) @(negedge clk);

        // ---- overrun: consumer stalled across two frames
        @(posedge clk); #2;
        ready_a = 1'b0;
        q_a.push_back('{data: 9'h011, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b11);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b11);
        chk("ovr_pulse_count", ovr_cnt_a, 1);
        chk("ovr_held_data", {24'b0, data_a}, 32'h11);
        chk("ovr_held_valid", {31'b0, valid_a}, 32'h1);
        @(posedge clk); #2;
        ready_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_drained_valid", {31'b0, valid_a}, 32'h0);
        chk("ovr_queue_empty", q_a.size(), 0);

        // ---- reset in the middle of data bit 4 of 0xFF
        @(negedge clk);
        rx_a = 1'b0;
        hold_bit();
        rx_a = 1'b1;
        repeat (4 * c_bit_clk + c_bit_clk / 2) @(negedge clk);
        chk("pre_reset_busy", {31'b0, busy_a}, 32'h1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_data_out", {24'b0, data_a}, 32'h0);
        chk("mid_rst_valid", {31'b0, valid_a}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy_a}, 32'h0);
        chk("mid_rst_state", {29'b0, state_a}, 32'h0);
        repeat (5 * c_bit_clk) @(negedge clk);
        chk("post_rst_still_idle", {31'b0, busy_a}, 32'h0);
        q_a.push_back('{data: 9'h081, perr: 1'b0, ferr: 1'b0});
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 2'b11);
        repeat (10) @(negedge clk);

        // ---- end-of-run scoreboard state
        chk("final_q_a_empty", q_a.size(), 0);
        chk("final_q_b_empty", q_b.size(), 0);
        chk("final_q_c_empty", q_c.size(), 0);
        chk("final_ovr_a", ovr_cnt_a, 1);
        chk("final_ovr_b", ovr_cnt_b, 0);
        chk("final_ovr_c", ovr_cnt_c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
